lab4_net_terminal_adapter: RTL

Endpoint network interface that sits between a terminal (core, memory port or test source/sink) and the terminal-facing port of a ring router. The inject path takes terminal messages (dest + payload), builds a net_hdr_t with src = terminal_id and a rolling opaque tag, and sends the message into the router. The eject path accepts messages from the router, checks the destination, and delivers src, opaque and payload to the terminal. Each direction has its own 2-entry buffer, so neither direction can stall the other.

---
 rtl/lab4_net_terminal_adapter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lab4_net_terminal_adapter.sv
// Terminal-side network adapter for the lab4 ring: stamps src/opaque onto
// injected messages and filters/delivers ejected ones, each through its own 2-deep FIFO.

package lab4_net_pkg;
    localparam int unsigned OPAQUE_NBITS = 8;
    localparam int unsigned ID_NBITS     = 2;

    typedef struct packed {
        logic [OPAQUE_NBITS-1:0] opaque;
        logic [ID_NBITS-1:0]     src;
        logic [ID_NBITS-1:0]     dest;
    } net_hdr_t;
endpackage

// Two-entry val/rdy FIFO; enq_rdy is forced low while reset is asserted.
module lab4_net_fifo2 #(
    parameter int unsigned p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_data,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_data
);
    logic [p_nbits-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               do_enq;
    logic               do_deq;

    assign enq_rdy  = reset && (count != 2'd2);
    assign deq_val  = (count != 2'd0);
    assign deq_data = mem[rd_ptr];
    assign do_enq   = enq_val && enq_rdy;
    assign do_deq   = deq_val && deq_rdy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_enq) wr_ptr <= ~wr_ptr;
            if (do_deq) rd_ptr <= ~rd_ptr;
            if (do_enq && !do_deq)
                count <= count + 2'd1;
            else if (!do_enq && do_deq)
                count <= count - 2'd1;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end
endmodule

module lab4_net_terminal_adapter
    import lab4_net_pkg::*;
#(
    parameter int unsigned p_payload_nbits = 32,
    parameter int unsigned p_opaque_nbits  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 terminal_id,

    input  logic [1:0]                 term_in_dest,
    input  logic [p_payload_nbits-1:0] term_in_payload,
    input  logic                       term_in_val,
    output logic                       term_in_rdy,

    output net_hdr_t                   net_out_msg_hdr,
    output logic [p_payload_nbits-1:0] net_out_msg_payload,
    output logic                       net_out_val,
    input  logic                       net_out_rdy,

    input  net_hdr_t                   net_in_msg_hdr,
    input  logic [p_payload_nbits-1:0] net_in_msg_payload,
    input  logic                       net_in_val,
    output logic                       net_in_rdy,

    output logic [1:0]                 term_out_src,
    output logic [p_opaque_nbits-1:0]  term_out_opaque,
    output logic [p_payload_nbits-1:0] term_out_payload,
    output logic                       term_out_val,
    input  logic                       term_out_rdy,

    output logic                       misroute_err,
    output logic [15:0]                inject_count,
    output logic [15:0]                eject_count
);
    localparam int unsigned HDR_NBITS = $bits(net_hdr_t);
    localparam int unsigned INJ_NBITS = HDR_NBITS + p_payload_nbits;
    localparam int unsigned EJ_NBITS  = ID_NBITS + OPAQUE_NBITS + p_payload_nbits;

    logic [p_opaque_nbits-1:0] opaque_ctr;
    net_hdr_t                  inj_hdr;
    logic [INJ_NBITS-1:0]      inj_deq_data;
    logic [EJ_NBITS-1:0]       ej_enq_data;
    logic [EJ_NBITS-1:0]       ej_deq_data;
    logic [OPAQUE_NBITS-1:0]   ej_opaque;
    logic                      dest_ok;
    logic                      inj_fire;
    logic                      net_in_fire;
    logic                      ej_fire;

    assign inj_hdr = '{opaque: OPAQUE_NBITS'(opaque_ctr),
                       src:    terminal_id,
                       dest:   term_in_dest};

    lab4_net_fifo2 #(.p_nbits(INJ_NBITS)) u_inj_q (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (term_in_val),
        .enq_rdy  (term_in_rdy),
        .enq_data ({inj_hdr, term_in_payload}),
        .deq_val  (net_out_val),
        .deq_rdy  (net_out_rdy),
        .deq_data (inj_deq_data)
    );

    assign {net_out_msg_hdr, net_out_msg_payload} = inj_deq_data;

    // Misrouted messages are still handshaken so the ring never wedges on them.
    assign dest_ok     = (net_in_msg_hdr.dest == terminal_id);
    assign ej_enq_data = {net_in_msg_hdr.src, net_in_msg_hdr.opaque, net_in_msg_payload};

    lab4_net_fifo2 #(.p_nbits(EJ_NBITS)) u_ej_q (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (net_in_val && dest_ok),
        .enq_rdy  (net_in_rdy),
        .enq_data (ej_enq_data),
        .deq_val  (term_out_val),
        .deq_rdy  (term_out_rdy),
        .deq_data (ej_deq_data)
    );

    assign {term_out_src, ej_opaque, term_out_payload} = ej_deq_data;
    assign term_out_opaque = p_opaque_nbits'(ej_opaque);

    assign inj_fire    = term_in_val && term_in_rdy;
    assign net_in_fire = net_in_val && net_in_rdy;
    assign ej_fire     = term_out_val && term_out_rdy;

    // Opaque tag generator, transfer counters and sticky misroute flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            opaque_ctr   <= '0;
            inject_count <= 16'd0;
            eject_count  <= 16'd0;
            misroute_err <= 1'b0;
        end else begin
            if (inj_fire) begin
                opaque_ctr   <= opaque_ctr + p_opaque_nbits'(1);
                inject_count <= inject_count + 16'd1;
            end
            if (ej_fire)
                eject_count <= eject_count + 16'd1;
            if (net_in_fire && !dest_ok)
                misroute_err <= 1'b1;
        end
    end
endmodule
